serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 129 ++++++++++++
 tb/tb_serial_frame_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a 4-bit sync pattern, shifts in DATA_W payload bits
// MSB first, checks a stop bit and hands the word to a valid/ready consumer.
//
// state | meaning
// HUNT  | shifting strobed bits into the sync window, waiting for SYNC_PAT
// DATA  | shifting payload bits into the data shift register
// STOP  | waiting for the stop bit (1 = deliver word, 0 = framing error)
module serial_frame_rx #(
   parameter logic [3:0] SYNC_PAT = 4'b1101,
   parameter int         DATA_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DIN,
   input  logic              DIN_EN,
   output logic [DATA_W-1:0] DOUT,
   output logic              DOUT_VLD,
   input  logic              DOUT_RDY,
   output logic              OVF,
   output logic              FERR,
   output logic [1:0]        STATE
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      HUNT = 2'b00,
      DATA = 2'b01,
      STOP = 2'b10
   } state_t;

   state_t            state, state_n;
   logic [3:0]        window, window_n;
   logic [1:0]        fill, fill_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DATA_W-1:0] dout_n;
   logic              vld_n, ovf_n, ferr_n;
   logic              frame_ok;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= HUNT;
         window   <= '0;
         fill     <= '0;
         shreg    <= '0;
         cnt      <= '0;
         DOUT     <= '0;
         DOUT_VLD <= 1'b0;
         OVF      <= 1'b0;
         FERR     <= 1'b0;
      end else begin
         state    <= state_n;
         window   <= window_n;
         fill     <= fill_n;
         shreg    <= shreg_n;
         cnt      <= cnt_n;
         DOUT     <= dout_n;
         DOUT_VLD <= vld_n;
         OVF      <= ovf_n;
         FERR     <= ferr_n;
      end
   end

   always_comb begin
      state_n  = state;
      window_n = window;
      fill_n   = fill;
      shreg_n  = shreg;
      cnt_n    = cnt;
      frame_ok = 1'b0;
      ferr_n   = 1'b0;
      case (state)
         HUNT: begin
            if (DIN_EN) begin
               window_n = {window[2:0], DIN};
               if (fill != 2'd3) fill_n = fill + 2'd1;
               if (({window[2:0], DIN} == SYNC_PAT) && (fill == 2'd3)) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
            end
         end
         DATA: begin
            if (DIN_EN) begin
               shreg_n = (shreg << 1) | DATA_W'(DIN);
               cnt_n   = cnt + CNT_W'(1);
               if (cnt == LAST_BIT) state_n = STOP;
            end
         end
         STOP: begin
            if (DIN_EN) begin
               if (DIN) frame_ok = 1'b1;
               else     ferr_n   = 1'b1;
               // Clearing the window keeps the stop bit out of the next sync search.
               state_n  = HUNT;
               window_n = '0;
               fill_n   = '0;
            end
         end
         default: begin
            state_n  = HUNT;
            window_n = '0;
            fill_n   = '0;
         end
      endcase
   end

   // Output handshake: a completing frame wins over a plain acknowledge.
   always_comb begin
      dout_n = DOUT;
      vld_n  = DOUT_VLD;
      ovf_n  = OVF;
      if (frame_ok) begin
         if (!DOUT_VLD || DOUT_RDY) begin
            dout_n = shreg;
            vld_n  = 1'b1;
         end else begin
            ovf_n  = 1'b1;
         end
      end else if (DOUT_VLD && DOUT_RDY) begin
         vld_n = 1'b0;
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a frame table for the delivery/handshake cases
// plus hand-written sequences for strobe gaps, stop-bit reuse and resets.
module tb_serial_frame_rx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       DIN = 1'b0;
   logic       DIN_EN = 1'b0;
   logic       DOUT_RDY = 1'b0;
   logic [7:0] DOUT;
   logic       DOUT_VLD, OVF, FERR;
   logic [1:0] STATE;

   int n_cmp = 0;
   int n_err = 0;

   serial_frame_rx #(.SYNC_PAT(4'b1101), .DATA_W(8)) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_EN(DIN_EN),
      .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY),
      .OVF(OVF), .FERR(FERR), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       rdy_stop;
      logic       ack;
      logic [7:0] exp_dout;
      logic       exp_vld;
      logic       exp_ovf;
      logic       exp_ferr;
      logic       exp_vld_idle;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b);
      DIN_EN = 1'b1;
      DIN    = b;
      tick();
      DIN_EN = 1'b0;
      DIN    = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, input logic rdy_stop);
      logic [3:0] sync;
      sync = 4'b1101;
      for (int i = 3; i >= 0; i--) send_bit(sync[i]);
      chk("state_after_sync", 32'(STATE), 32'd1);
      for (int i = 7; i >= 0; i--) send_bit(data[i]);
      chk("state_after_data", 32'(STATE), 32'd2);
      DOUT_RDY = rdy_stop;
      send_bit(stop);
      DOUT_RDY = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      logic [3:0] sync;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};

      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_state", 32'(STATE), 32'd0);
      chk("rst_dout", 32'(DOUT), 32'd0);
      chk("rst_vld", 32'(DOUT_VLD), 32'd0);
      chk("rst_ovf", 32'(OVF), 32'd0);
      chk("rst_ferr", 32'(FERR), 32'd0);

      for (int v = 0; v < 7; v++) begin
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].rdy_stop);
         chk($sformatf("v%0d_dout", v), 32'(DOUT), 32'(vecs[v].exp_dout));
         chk($sformatf("v%0d_vld", v), 32'(DOUT_VLD), 32'(vecs[v].exp_vld));
         chk($sformatf("v%0d_ovf", v), 32'(OVF), 32'(vecs[v].exp_ovf));
         chk($sformatf("v%0d_ferr", v), 32'(FERR), 32'(vecs[v].exp_ferr));
         chk($sformatf("v%0d_state", v), 32'(STATE), 32'd0);
         DOUT_RDY = vecs[v].ack;
         tick();
         DOUT_RDY = 1'b0;
         chk($sformatf("v%0d_vld_idle", v), 32'(DOUT_VLD), 32'(vecs[v].exp_vld_idle));
         chk($sformatf("v%0d_ferr_idle", v), 32'(FERR), 32'd0);
      end

      // Strobe gaps: every other edge has DIN_EN=0 with random DIN.
      w    = 8'hA5;
      sync = 4'b1101;
      for (int i = 12; i >= 0; i--) begin
         if (i > 8)      DIN = sync[i-9];
         else if (i > 0) DIN = w[i-1];
         else            DIN = 1'b1;
         DIN_EN = 1'b1;
         tick();
         DIN_EN = 1'b0;
         DIN    = 1'($urandom_range(0, 1));
         tick();
      end
      DIN = 1'b0;
      chk("gap_dout", 32'(DOUT), 32'hA5);
      chk("gap_vld", 32'(DOUT_VLD), 32'd1);
      chk("gap_ovf_sticky", 32'(OVF), 32'd1);

      // Only three bits after a frame must not complete a sync match.
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("no_stop_reuse", 32'(STATE), 32'd0);
      chk("pending_held", 32'(DOUT), 32'hA5);

      // Reset has priority over asserted inputs and discards the pending word.
      RST = 1'b1; DIN_EN = 1'b1; DIN = 1'b1; DOUT_RDY = 1'b1;
      tick();
      RST = 1'b0; DIN_EN = 1'b0; DIN = 1'b0; DOUT_RDY = 1'b0;
      chk("rst2_state", 32'(STATE), 32'd0);
      chk("rst2_dout", 32'(DOUT), 32'd0);
      chk("rst2_vld", 32'(DOUT_VLD), 32'd0);
      chk("rst2_ovf", 32'(OVF), 32'd0);
      chk("rst2_ferr", 32'(FERR), 32'd0);

      // Reset mid-frame after four payload bits.
      for (int i = 3; i >= 0; i--) send_bit(sync[i]);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      chk("mid_state_data", 32'(STATE), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("mid_rst_state", 32'(STATE), 32'd0);
      chk("mid_rst_vld", 32'(DOUT_VLD), 32'd0);
      chk("mid_rst_dout", 32'(DOUT), 32'd0);
      tick();
      chk("mid_no_vld", 32'(DOUT_VLD), 32'd0);
      send_frame(8'h5A, 1'b1, 1'b0);
      chk("after_rst_dout", 32'(DOUT), 32'h5A);
      chk("after_rst_vld", 32'(DOUT_VLD), 32'd1);
      chk("after_rst_ovf", 32'(OVF), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
